// File: rtl/ad9826_spi.sv
// AD9826 3-wire serial port master: 16-bit frames, MSB first, sload framing.
// Define AD9826_SPI_READBACK_EN to enable read frames (pad turnaround + rdata capture).
module ad9826_spi #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [8:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [8:0] rdata,
    output logic       ad_sload,
    output logic       ad_sclk,
    output logic       ad_sdata_o,
    output logic       ad_sdata_oe,
    input  logic       ad_sdata_i
);

`ifdef AD9826_SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        phase_q, phase_d;   // 0 = sclk low phase, 1 = high phase
    logic [15:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic        oe_q, oe_d;
    logic [8:0]  rsh_q, rsh_d;
    logic [8:0]  rdata_q, rdata_d;

    logic cnt_end;
    logic rw_eff;
    logic in_frame;

    assign cnt_end  = (cnt_q == CNT_LAST);
    assign rw_eff   = READBACK & rw;
    assign in_frame = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            oe_q    <= 1'b1;
            rsh_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
            rsh_q   <= rsh_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        oe_d    = oe_q;
        rsh_d   = rsh_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = {rw_eff, addr, 3'b000, (rw_eff ? 9'h000 : wdata)};
                    rd_d    = rw_eff;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    rsh_d   = '0;
                    oe_d    = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_end) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_end) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        // Rising sclk edge: capture readback bits from period 8 on.
                        phase_d = 1'b1;
                        if (READBACK && rd_q && (bit_q >= 4'd7))
                            rsh_d = {rsh_q[7:0], ad_sdata_i};
                    end else if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        // Falling edge: next bit goes out at the start of the low phase.
                        phase_d = 1'b0;
                        bit_d   = bit_q + 4'd1;
                        sh_d    = {sh_q[14:0], 1'b0};
                        if (rd_q && (bit_q == 4'd6))
                            oe_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_end) begin
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    state_d = S_DONE;
                    if (rd_q)
                        rdata_d = rsh_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign ad_sload    = ~in_frame;
    assign ad_sclk     = (state_q == S_SHIFT) && phase_q;
    assign ad_sdata_o  = in_frame && sh_q[15];
    assign ad_sdata_oe = READBACK ? oe_q : 1'b1;
    assign rdata       = READBACK ? rdata_q : 9'h000;

endmodule

// File: tb/tb_ad9826_spi.sv
// Directed bench for ad9826_spi (CLK_DIV=4); read expectations follow AD9826_SPI_READBACK_EN.
module tb_ad9826_spi;

`ifdef AD9826_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [2:0] addr = '0;
    logic [8:0] wdata = '0;
    logic       busy, done;
    logic [8:0] rdata;
    logic       ad_sload, ad_sclk, ad_sdata_o, ad_sdata_oe;
    logic       ad_sdata_i = 1'b0;

    int checks = 0;
    int errors = 0;

    ad9826_spi #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .ad_sload(ad_sload), .ad_sclk(ad_sclk), .ad_sdata_o(ad_sdata_o),
        .ad_sdata_oe(ad_sdata_oe), .ad_sdata_i(ad_sdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic launch(input logic r, input logic [2:0] a, input logic [8:0] w);
        start = 1'b1; rw = r; addr = a; wdata = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes a frame until the done cycle (returns at that negedge) or a 400-cycle timeout.
    task automatic capture(input logic rd_exp, input logic [8:0] sdi_word, input bit noisy,
                           output logic [15:0] bits, output int nsl, output int nrise,
                           output int nhigh, output int ndone, output int oe_bad);
        logic prev = 1'b0;
        bits = '0; nsl = 0; nrise = 0; nhigh = 0; ndone = 0; oe_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (noisy) begin
                start = (i == 5) || (i == 10) || (i == 50);
                rw = 1'b1; addr = 3'h1; wdata = 9'h1FF;
            end
            if (ad_sload === 1'b0) nsl++;
            if (ad_sclk === 1'b1) nhigh++;
            if (!prev && ad_sclk === 1'b1) begin
                bits = {bits[14:0], ad_sdata_o};
                nrise++;
                if (ad_sdata_oe !== ((rd_exp && nrise >= 8) ? 1'b0 : 1'b1)) oe_bad++;
            end
            if (prev && ad_sclk === 1'b0 && nrise >= 7 && nrise <= 15)
                ad_sdata_i = sdi_word[15 - nrise];
            if (done === 1'b1) begin
                ndone = 1;
                break;
            end
            prev = ad_sclk;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [15:0] bits;
    int nsl, nrise, nhigh, ndone, oe_bad;
    logic [8:0] rd_keep;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sload", ad_sload, 1);
        chk("rst_sclk", ad_sclk, 0);
        chk("rst_sdo", ad_sdata_o, 0);
        chk("rst_oe", ad_sdata_oe, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame 0x0D8 to address 0
        launch(1'b0, 3'b000, 9'h0D8);
        chk("wr_busy", busy, 1);
        chk("wr_setup_sdo", ad_sdata_o, 0);
        capture(1'b0, 9'h000, 1'b0, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("wr_bits", bits, 16'h00D8);
        chk("wr_sload_len", nsl, 136);
        chk("wr_rises", nrise, 16);
        chk("wr_sclk_high", nhigh, 64);
        chk("wr_done", ndone, 1);
        chk("wr_oe", oe_bad, 0);
        chk("wr_rdata", rdata, 0);
        @(negedge clk);
        chk("wr_done_single", done, 0);
        chk("wr_idle_busy", busy, 0);

        // Read frame from address 2, pad returns 0x155
        launch(1'b1, 3'b010, 9'h0AA);
        capture(RB, 9'h155, 1'b0, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("rd_bits", bits, RB ? 16'hA000 : 16'h20AA);
        chk("rd_done", ndone, 1);
        chk("rd_rdata", rdata, RB ? 9'h155 : 9'h000);
        chk("rd_oe_periods", oe_bad, 0);
        chk("rd_oe_done", ad_sdata_oe, 1);
        chk("rd_sload_len", nsl, 136);
        rd_keep = RB ? 9'h155 : 9'h000;
        @(negedge clk);

        // Starts while busy at cycles 5, 10, 50 are ignored; write keeps rdata
        launch(1'b0, 3'b110, 9'h0B5);
        capture(1'b0, 9'h000, 1'b1, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("nz_bits", bits, 16'h60B5);
        chk("nz_rises", nrise, 16);
        chk("nz_done", ndone, 1);
        chk("nz_rdata_kept", rdata, rd_keep);
        nsl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ad_sload === 1'b0 || busy === 1'b1) nsl++;
        end
        chk("nz_no_extra_frame", nsl, 0);

        // Reset in period 6 aborts the frame
        launch(1'b0, 3'b011, 9'h1C3);
        repeat (46) @(negedge clk);
        chk("ab_midframe_sload", ad_sload, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("ab_sload", ad_sload, 1);
        chk("ab_sclk", ad_sclk, 0);
        chk("ab_busy", busy, 0);
        chk("ab_rdata", rdata, 0);
        nsl = 0; ndone = 0;
        for (int i = 0; i < 150; i++) begin
            if (done === 1'b1) ndone++;
            if (ad_sload === 1'b0) nsl++;
            @(negedge clk);
        end
        chk("ab_no_done", ndone, 0);
        chk("ab_no_sload", nsl, 0);
        launch(1'b0, 3'b101, 9'h123);
        capture(1'b0, 9'h000, 1'b0, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("ab_next_bits", bits, 16'h5123);
        chk("ab_next_done", ndone, 1);
        @(negedge clk);

        // Back-to-back: start in done cycle ignored, start in next cycle accepted
        launch(1'b0, 3'b001, 9'h0F0);
        capture(1'b0, 9'h000, 1'b0, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("bb_a_bits", bits, 16'h10F0);
        chk("bb_a_done", ndone, 1);
        start = 1'b1; rw = 1'b0; addr = 3'h7; wdata = 9'h1FF;
        @(negedge clk);
        start = 1'b0;
        chk("bb_done_start_ignored", busy, 0);
        launch(1'b0, 3'b100, 9'h1A5);
        chk("bb_b_accepted", busy, 1);
        capture(1'b0, 9'h000, 1'b0, bits, nsl, nrise, nhigh, ndone, oe_bad);
        chk("bb_b_bits", bits, 16'h41A5);
        chk("bb_b_sload_len", nsl, 136);
        chk("bb_b_done", ndone, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
